// File: rtl/cpc_bus_pkg.sv
// ---------------------------------------------------------------------------
// cpc_bus_pkg
// Shared definitions for the CPC bus front-end and the RAM-mapping stage:
//   - cyc_type_e  : bus cycle classification (NONE..INTACK)
//   - bus_state_e : cycle monitor state encoding (IDLE, ACTIVE, END)
//   - BANK_A15 / BANK_SEL : match values for the 0x7FXX bank-select port
//   - classify_cycle : start-clock classification of a Z80 bus cycle
//   - is_io_cycle    : true for cycles terminated by IORQ rather than MREQ
// ---------------------------------------------------------------------------
package cpc_bus_pkg;

    typedef enum logic [2:0] {
        CYC_NONE   = 3'd0,
        CYC_FETCH  = 3'd1,
        CYC_MRD    = 3'd2,
        CYC_MWR    = 3'd3,
        CYC_RFSH   = 3'd4,
        CYC_IORD   = 3'd5,
        CYC_IOWR   = 3'd6,
        CYC_INTACK = 3'd7
    } cyc_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_END    = 2'd2
    } bus_state_e;

    localparam logic       BANK_A15 = 1'b0;
    localparam logic [1:0] BANK_SEL = 2'b11;

    // Priority-ordered classification of the start-clock sample. A memory
    // cycle with RD high is taken as a write because WR lags MREQ on the Z80.
    // An IO cycle with neither strobe yet is reported as IOWR; the caller
    // treats that as provisional.
    function automatic cyc_type_e classify_cycle(
        input logic mreq_b,
        input logic iorq_b,
        input logic rd_b,
        input logic m1_b,
        input logic rfsh_b
    );
        if (!rfsh_b)              return CYC_RFSH;
        else if (!mreq_b && !m1_b) return CYC_FETCH;
        else if (!mreq_b && !rd_b) return CYC_MRD;
        else if (!mreq_b)          return CYC_MWR;
        else if (!iorq_b && !m1_b) return CYC_INTACK;
        else if (!iorq_b && !rd_b) return CYC_IORD;
        else if (!iorq_b)          return CYC_IOWR;
        else                       return CYC_NONE;
    endfunction

    function automatic logic is_io_cycle(input cyc_type_e t);
        return (t == CYC_IORD) || (t == CYC_IOWR) || (t == CYC_INTACK);
    endfunction

endpackage

// File: rtl/cpc_bank_port_decode.sv
// ---------------------------------------------------------------------------
// cpc_bank_port_decode
// Decodes writes to the 0x7FXX bank-select port with data[7:6]=11 and holds
// the resulting 6-bit bank configuration. Only the first qualifying clock of
// each IO write cycle updates the register.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   cyc_start_evt  : a new bus cycle is being accepted this clock
//   iowr_active    : monitor is in ACTIVE with an IOWR cycle latched
//   wr_b, adr15    : sampled Z80 write strobe and address bit 15
//   data           : sampled data bus
//   bank_wr        : one-clock pulse when bank_cfg is updated
//   bank_cfg       : last accepted data[5:0]
// ---------------------------------------------------------------------------
module cpc_bank_port_decode
    import cpc_bus_pkg::*;
#(
    parameter logic [5:0] CFG_RESET = 6'b000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cyc_start_evt,
    input  logic       iowr_active,
    input  logic       wr_b,
    input  logic       adr15,
    input  logic [7:0] data,
    output logic       bank_wr,
    output logic [5:0] bank_cfg
);

    logic wr_done;
    logic hit;

    // wr_done blocks further updates while WR stays low for several clocks.
    assign hit = iowr_active && !wr_done && !wr_b &&
                 (adr15 == BANK_A15) && (data[7:6] == BANK_SEL);

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_wr  <= 1'b0;
            bank_cfg <= CFG_RESET;
            wr_done  <= 1'b0;
        end else begin
            bank_wr <= hit;
            if (cyc_start_evt) begin
                wr_done <= 1'b0;
            end else if (hit) begin
                wr_done <= 1'b1;
            end
            if (hit) begin
                bank_cfg <= data[5:0];
            end
        end
    end

endmodule

// File: rtl/cpc_bus_cycle_monitor.sv
// ---------------------------------------------------------------------------
// cpc_bus_cycle_monitor
// Samples Z80 bus strobes on the CPC clock, classifies each bus cycle and
// produces registered cycle-type, start/end/abort strobes, a memory-write
// window and a saturating wait-state count. Also hosts the bank-select port
// decoder.
// Ports:
//   clk, reset          : 4 MHz bus clock, synchronous active-high reset
//   mreq_b .. rfsh_b    : Z80 strobes, active-low
//   ready               : wait line, high = no wait
//   adr15, data         : address bit 15 and data bus
//   cyc_type            : type of current/last cycle
//   cyc_start, cyc_end  : one-clock pulses at cycle start / normal end
//   cyc_abort           : one-clock pulse when a cycle times out
//   mwr_active          : high through ACTIVE and END of a memory write
//   wait_cnt            : ready-low clocks in the current cycle, saturating
//   bank_wr, bank_cfg   : bank-select update pulse and register
// ---------------------------------------------------------------------------
module cpc_bus_cycle_monitor
    import cpc_bus_pkg::*;
#(
    parameter logic [5:0] CFG_RESET = 6'b000000,
    parameter int         WAIT_W    = 3,
    parameter int         MAX_CYC   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mreq_b,
    input  logic              iorq_b,
    input  logic              rd_b,
    input  logic              wr_b,
    input  logic              m1_b,
    input  logic              rfsh_b,
    input  logic              ready,
    input  logic              adr15,
    input  logic [7:0]        data,
    output logic [2:0]        cyc_type,
    output logic              cyc_start,
    output logic              cyc_end,
    output logic              mwr_active,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              bank_wr,
    output logic [5:0]        bank_cfg,
    output logic              cyc_abort
);

    localparam int TMO_W = $clog2(MAX_CYC + 1);

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              mreq_b_p1;
    logic              iorq_b_p1;
    bus_state_e        state;
    cyc_type_e         cyc_type_q;
    logic              prov_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_next;
    logic              start_evt;
    logic              start_acc;
    logic              start_prov;
    logic              req_high;
    logic              iowr_active;
    cyc_type_e         start_type;

    // Stage p1: previous strobe levels for falling-edge detection. These
    // follow the bus during reset too, so a strobe held low across reset
    // does not produce a spurious start.
    always_ff @(posedge clk) begin
        mreq_b_p1 <= mreq_b;
        iorq_b_p1 <= iorq_b;
    end

    assign start_evt   = (mreq_b_p1 && !mreq_b) || (iorq_b_p1 && !iorq_b);
    assign start_acc   = start_evt && (state != ST_ACTIVE);
    assign start_type  = classify_cycle(mreq_b, iorq_b, rd_b, m1_b, rfsh_b);
    assign start_prov  = (start_type == CYC_IOWR) && wr_b;
    assign req_high    = is_io_cycle(cyc_type_q) ? iorq_b : mreq_b;
    assign tmo_next    = tmo_cnt + 1'b1;
    assign iowr_active = (state == ST_ACTIVE) && (cyc_type_q == CYC_IOWR);
    assign cyc_type    = cyc_type_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cyc_type_q <= CYC_NONE;
            prov_q     <= 1'b0;
            tmo_cnt    <= '0;
            wait_cnt   <= '0;
            cyc_start  <= 1'b0;
            cyc_end    <= 1'b0;
            cyc_abort  <= 1'b0;
            mwr_active <= 1'b0;
        end else begin
            cyc_start <= 1'b0;
            cyc_end   <= 1'b0;
            cyc_abort <= 1'b0;
            case (state)
                ST_IDLE, ST_END: begin
                    // END also accepts a new start so an M1 fetch can be
                    // followed by its refresh cycle without an IDLE gap.
                    if (start_acc) begin
                        state      <= ST_ACTIVE;
                        cyc_start  <= 1'b1;
                        cyc_type_q <= start_type;
                        prov_q     <= start_prov;
                        wait_cnt   <= '0;
                        tmo_cnt    <= '0;
                        mwr_active <= (start_type == CYC_MWR);
                    end else begin
                        state      <= ST_IDLE;
                        mwr_active <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    prov_q <= 1'b0;
                    // A provisional IOWR becomes IORD once RD shows up.
                    if (prov_q && !rd_b) begin
                        cyc_type_q <= CYC_IORD;
                    end
                    if (req_high) begin
                        state   <= ST_END;
                        cyc_end <= 1'b1;
                    end else if (tmo_next == TMO_W'(MAX_CYC)) begin
                        state      <= ST_IDLE;
                        cyc_type_q <= CYC_NONE;
                        cyc_abort  <= 1'b1;
                        mwr_active <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_next;
                        if (!ready) begin
                            wait_cnt <= sat_inc(wait_cnt);
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    mwr_active <= 1'b0;
                end
            endcase
        end
    end

    cpc_bank_port_decode #(
        .CFG_RESET (CFG_RESET)
    ) u_bank_port_decode (
        .clk           (clk),
        .reset         (reset),
        .cyc_start_evt (start_acc),
        .iowr_active   (iowr_active),
        .wr_b          (wr_b),
        .adr15         (adr15),
        .data          (data),
        .bank_wr       (bank_wr),
        .bank_cfg      (bank_cfg)
    );

endmodule

// File: tb/tb_cpc_bus_cycle_monitor.sv
// ---------------------------------------------------------------------------
// tb_cpc_bus_cycle_monitor
// Directed stimulus pushes the expected output event for each bus cycle into
// a queue; a monitor pops one entry whenever the DUT shows a start, end,
// abort or bank-write pulse and compares the full output snapshot.
// A second instance with CFG_RESET=6'h3F shares the bus for reset checks.
// ---------------------------------------------------------------------------
module tb_cpc_bus_cycle_monitor;

    localparam logic [3:0] EV_START = 4'b1000;
    localparam logic [3:0] EV_END   = 4'b0100;
    localparam logic [3:0] EV_ABORT = 4'b0010;
    localparam logic [3:0] EV_BANK  = 4'b0001;

    typedef struct {
        logic [3:0] code;
        logic [2:0] typ;
        logic [2:0] wcnt;
        logic [5:0] cfg;
        logic       mwr;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, ready, adr15;
    logic [7:0] data;

    logic [2:0] cyc_type, cyc_type2;
    logic       cyc_start, cyc_end, mwr_active, bank_wr, cyc_abort;
    logic       cyc_start2, cyc_end2, mwr_active2, bank_wr2, cyc_abort2;
    logic [2:0] wait_cnt, wait_cnt2;
    logic [5:0] bank_cfg, bank_cfg2;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    cpc_bus_cycle_monitor dut (
        .clk(clk), .reset(reset), .mreq_b(mreq_b), .iorq_b(iorq_b),
        .rd_b(rd_b), .wr_b(wr_b), .m1_b(m1_b), .rfsh_b(rfsh_b),
        .ready(ready), .adr15(adr15), .data(data),
        .cyc_type(cyc_type), .cyc_start(cyc_start), .cyc_end(cyc_end),
        .mwr_active(mwr_active), .wait_cnt(wait_cnt), .bank_wr(bank_wr),
        .bank_cfg(bank_cfg), .cyc_abort(cyc_abort)
    );

    cpc_bus_cycle_monitor #(.CFG_RESET(6'h3F)) dut2 (
        .clk(clk), .reset(reset), .mreq_b(mreq_b), .iorq_b(iorq_b),
        .rd_b(rd_b), .wr_b(wr_b), .m1_b(m1_b), .rfsh_b(rfsh_b),
        .ready(ready), .adr15(adr15), .data(data),
        .cyc_type(cyc_type2), .cyc_start(cyc_start2), .cyc_end(cyc_end2),
        .mwr_active(mwr_active2), .wait_cnt(wait_cnt2), .bank_wr(bank_wr2),
        .bank_cfg(bank_cfg2), .cyc_abort(cyc_abort2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] code, input logic [2:0] typ,
                        input logic [2:0] wcnt, input logic [5:0] cfg, input logic mwr);
        exp_t e;
        e.code = code; e.typ = typ; e.wcnt = wcnt; e.cfg = cfg; e.mwr = mwr;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Outputs only change on posedge, so the negedge is a stable sample point.
    always @(negedge clk) begin
        logic [3:0] code;
        exp_t e;
        code = {cyc_start, cyc_end, cyc_abort, bank_wr};
        if (code != 4'b0000) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got code %b, expected no event", code);
            end else begin
                e = exp_q.pop_front();
                chk("event_code", 32'(code), 32'(e.code));
                chk("cyc_type", 32'(cyc_type), 32'(e.typ));
                chk("wait_cnt", 32'(wait_cnt), 32'(e.wcnt));
                chk("bank_cfg", 32'(bank_cfg), 32'(e.cfg));
                chk("mwr_active", 32'(mwr_active), 32'(e.mwr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        mreq_b = 1'b1; iorq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1;
        m1_b = 1'b1; rfsh_b = 1'b1; ready = 1'b1; adr15 = 1'b0; data = 8'h00;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rst_cyc_type", 32'(cyc_type), 32'd0);
        chk("rst_bank_cfg", 32'(bank_cfg), 32'h00);
        chk("rst_bank_cfg_3f", 32'(bank_cfg2), 32'h3F);
        chk("rst_pulses", 32'({cyc_start, cyc_end, cyc_abort, bank_wr}), 32'd0);
        chk("rst_mwr_active", 32'(mwr_active), 32'd0);
        chk("rst_wait_cnt", 32'(wait_cnt), 32'd0);

        // Memory write, two wait states
        push(EV_START, 3'd3, 3'd0, 6'h00, 1'b1);
        mreq_b = 1'b0; tick(1);
        wr_b = 1'b0; ready = 1'b0; tick(2);
        ready = 1'b1; tick(1);
        push(EV_END, 3'd3, 3'd2, 6'h00, 1'b1);
        mreq_b = 1'b1; wr_b = 1'b1; tick(2);
        chk("mwr_window_closed", 32'(mwr_active), 32'd0);

        // Fetch immediately followed by refresh
        push(EV_START, 3'd1, 3'd0, 6'h00, 1'b0);
        mreq_b = 1'b0; m1_b = 1'b0; rd_b = 1'b0; tick(2);
        push(EV_END, 3'd1, 3'd0, 6'h00, 1'b0);
        mreq_b = 1'b1; m1_b = 1'b1; rd_b = 1'b1; tick(1);
        push(EV_START, 3'd4, 3'd0, 6'h00, 1'b0);
        mreq_b = 1'b0; rfsh_b = 1'b0; tick(2);
        push(EV_END, 3'd4, 3'd0, 6'h00, 1'b0);
        mreq_b = 1'b1; rfsh_b = 1'b1; tick(2);

        // Bank write 0x7F00 <- C5, WR low 3 clocks
        push(EV_START, 3'd6, 3'd0, 6'h00, 1'b0);
        iorq_b = 1'b0; wr_b = 1'b0; adr15 = 1'b0; data = 8'hC5; tick(1);
        push(EV_BANK, 3'd6, 3'd0, 6'h05, 1'b0);
        tick(3);
        push(EV_END, 3'd6, 3'd0, 6'h05, 1'b0);
        iorq_b = 1'b1; wr_b = 1'b1; tick(2);

        // IO write with data[7:6]=10: ignored
        push(EV_START, 3'd6, 3'd0, 6'h05, 1'b0);
        iorq_b = 1'b0; wr_b = 1'b0; data = 8'h85; tick(3);
        push(EV_END, 3'd6, 3'd0, 6'h05, 1'b0);
        iorq_b = 1'b1; wr_b = 1'b1; tick(2);

        // IO write with adr15=1: ignored
        push(EV_START, 3'd6, 3'd0, 6'h05, 1'b0);
        iorq_b = 1'b0; wr_b = 1'b0; adr15 = 1'b1; data = 8'hC9; tick(3);
        push(EV_END, 3'd6, 3'd0, 6'h05, 1'b0);
        iorq_b = 1'b1; wr_b = 1'b1; adr15 = 1'b0; tick(2);

        // IO read, RD with IORQ
        push(EV_START, 3'd5, 3'd0, 6'h05, 1'b0);
        iorq_b = 1'b0; rd_b = 1'b0; tick(2);
        push(EV_END, 3'd5, 3'd0, 6'h05, 1'b0);
        iorq_b = 1'b1; rd_b = 1'b1; tick(2);

        // IO cycle with no strobe at start, RD one clock later
        push(EV_START, 3'd6, 3'd0, 6'h05, 1'b0);
        iorq_b = 1'b0; tick(1);
        rd_b = 1'b0; tick(2);
        push(EV_END, 3'd5, 3'd0, 6'h05, 1'b0);
        iorq_b = 1'b1; rd_b = 1'b1; tick(2);

        // Memory read with 10 wait clocks: counter saturates at 7
        push(EV_START, 3'd2, 3'd0, 6'h05, 1'b0);
        mreq_b = 1'b0; rd_b = 1'b0; tick(1);
        ready = 1'b0; tick(10);
        ready = 1'b1;
        push(EV_END, 3'd2, 3'd7, 6'h05, 1'b0);
        mreq_b = 1'b1; rd_b = 1'b1; tick(2);

        // MREQ stuck low for 20 clocks: abort 15 clocks after start
        push(EV_START, 3'd2, 3'd0, 6'h05, 1'b0);
        mreq_b = 1'b0; rd_b = 1'b0; tick(1);
        push(EV_ABORT, 3'd0, 3'd0, 6'h05, 1'b0);
        tick(19);
        mreq_b = 1'b1; rd_b = 1'b1; tick(2);
        chk("abort_type_held", 32'(cyc_type), 32'd0);
        push(EV_START, 3'd2, 3'd0, 6'h05, 1'b0);
        mreq_b = 1'b0; rd_b = 1'b0; tick(2);
        push(EV_END, 3'd2, 3'd0, 6'h05, 1'b0);
        mreq_b = 1'b1; rd_b = 1'b1; tick(2);

        // Reset during a qualifying bank write
        push(EV_START, 3'd6, 3'd0, 6'h05, 1'b0);
        iorq_b = 1'b0; wr_b = 1'b0; data = 8'hFF; tick(1);
        reset = 1'b1; tick(2);
        iorq_b = 1'b1; wr_b = 1'b1; tick(1);
        reset = 1'b0; tick(1);
        chk("midrst_bank_cfg", 32'(bank_cfg), 32'h00);
        chk("midrst_bank_cfg_3f", 32'(bank_cfg2), 32'h3F);
        chk("midrst_cyc_type", 32'(cyc_type), 32'd0);
        chk("midrst_mwr_active", 32'(mwr_active), 32'd0);

        tick(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events: %0d events never seen, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpc_bus_cycle_monitor.md
Name: cpc_bus_cycle_monitor

Overview:
Upstream front-end for the RAM expansion banking logic. Samples Z80 bus strobes on the CPC clock, classifies each bus cycle, and produces registered cycle-type, start/end strobes and a memory-write window. Also decodes writes to the 0x7FXX bank-select port with data[7:6]=11 into a registered 6-bit bank configuration. The RAM-mapping stage consumes these outputs instead of re-deriving them from raw strobes.

Parameters:
CFG_RESET, 6'b000000, bank_cfg value after reset
WAIT_W, 3, width of the saturating wait-state counter
MAX_CYC, 15, clocks after which an unterminated cycle is aborted

Ports:
clk  in  1  CPC 4 MHz bus clock; all state changes on rising edge
reset  in  1  synchronous, active-high
mreq_b  in  1  Z80 memory request, active-low
iorq_b  in  1  Z80 IO request, active-low
rd_b  in  1  Z80 read strobe, active-low
wr_b  in  1  Z80 write strobe, active-low
m1_b  in  1  Z80 M1, active-low
rfsh_b  in  1  Z80 refresh, active-low
ready  in  1  CPC wait line, high = no wait
adr15  in  1  address bit 15
data  in  8  data bus
cyc_type  out  3  type of the current/last cycle (encoding below)
cyc_start  out  1  one-clock pulse on the first sampled clock of a cycle
cyc_end  out  1  one-clock pulse when a cycle terminates normally
mwr_active  out  1  high from memory-write start through the END state
wait_cnt  out  WAIT_W  ready-low clocks in the current cycle, saturating
bank_wr  out  1  one-clock pulse when bank_cfg is updated
bank_cfg  out  6  last accepted bank-select data[5:0]
cyc_abort  out  1  one-clock pulse on timeout abort

Behaviour:
- Reset: state IDLE, cyc_type NONE, all pulses 0, mwr_active 0, wait_cnt 0, bank_cfg CFG_RESET. Reset wins over every other event in the same clock.
- Inputs are used as sampled on the rising edge. Previous mreq_b and iorq_b are held in registers for edge detection.
- Cycle type encoding: NONE=0, FETCH=1, MRD=2, MWR=3, RFSH=4, IORD=5, IOWR=6, INTACK=7.
- Start is a falling edge of mreq_b or iorq_b (previous 1, current 0). Classification uses the start-clock sample, in priority order:
  - !rfsh_b -> RFSH
  - !mreq_b & !m1_b -> FETCH
  - !mreq_b & !rd_b -> MRD
  - !mreq_b & rd_b -> MWR; Z80 WR lags MREQ, so the write is inferred
  - !iorq_b & !m1_b -> INTACK
  - !iorq_b & !rd_b -> IORD
  - !iorq_b & !wr_b -> IOWR
  - !iorq_b with neither strobe -> IOWR provisional, confirmed or reclassified to IORD on the next clock
- States:
  - IDLE: on start -> ACTIVE, pulse cyc_start, latch cyc_type, clear wait_cnt.
  - ACTIVE: each clock with ready=0 increments wait_cnt, saturating at 2^WAIT_W-1. When the request of the latched kind is sampled high -> END.
  - END: pulse cyc_end. A new start sampled in END goes directly to ACTIVE (back-to-back M1 then refresh); otherwise -> IDLE.
- mwr_active is 1 in ACTIVE and END when cyc_type=MWR, and 0 otherwise. Output latency is one clock from the sampled strobe edge.
- Timeout: a clock counter runs in ACTIVE. On reaching MAX_CYC, pulse cyc_abort, go to IDLE and set cyc_type NONE. cyc_end is not pulsed on an abort.
- Bank write:
  - Condition: in ACTIVE with cyc_type=IOWR, and the first clock with !wr_b & !adr15 & data[7:6]==2'b11.
  - Action: bank_cfg <= data[5:0] and pulse bank_wr.
  - At most one update per IO cycle; a per-cycle flag is cleared at start.
  - IO writes with adr15=1 or data[7:6]!=11 leave bank_cfg unchanged.
- cyc_type holds its value after END until the next start, for consumers that sample late.

Decomposition:
- Shared package cpc_bus_pkg holds: the cycle-type enum/localparams (NONE..INTACK), the state encoding (IDLE, ACTIVE, END), and the bank port constants (A15=0, data[7:6]=11). The RAM-mapping stage uses the same package.
- One sub-module, cpc_bank_port_decode: the IO-write decode, per-cycle flag and bank_cfg register. Kept separate so the mapping stage can reuse it standalone.

Test Plan:
- Reset for 2 clocks, release -> bank_cfg=6'h00, cyc_type=0, all pulses 0; with CFG_RESET=6'h3F, bank_cfg=6'h3F.
- Memory write: mreq_b falls with rd_b=1, wr_b low one clock later, ready=0 for 2 clocks, then mreq_b rises -> cyc_start 1 clock after the edge, cyc_type=3, mwr_active high through END, wait_cnt=2, one cyc_end.
- Fetch followed immediately by refresh (mreq_b high for one clock in END) -> two cyc_start pulses, cyc_type 1 then 4, no IDLE gap.
- IO write to 0x7F00 with data=8'hC5 -> bank_wr one pulse, bank_cfg=6'h05. Data=8'h85 or adr15=1 -> no pulse, bank_cfg unchanged. wr_b held low 3 clocks -> still a single bank_wr.
- mreq_b held low 20 clocks -> cyc_abort at clock MAX_CYC=15, cyc_type=0, no cyc_end, next edge starts normally.
- Reset asserted mid-IOWR with data=8'hFF -> bank_cfg=CFG_RESET, state IDLE, no bank_wr.
